neighbor_builder: RTL

//  Builds the per-vertex adjacency table in neighbor RAM from the face list in object RAM.

---
 rtl/neighbor_builder.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/neighbor_builder.sv
// Builds per-vertex adjacency slots in neighbor RAM from the triangle list in object RAM.
// Each slot holds a count word followed by up to MAX_NEIGHBOR_COUNT-1 unique 1-based neighbors.
module neighbor_builder #(
    parameter int unsigned MAX_NEIGHBOR_COUNT = 10,
    parameter int unsigned ADDR_WIDTH         = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           vertex_count,
    input  logic [31:0]           face_count,
    input  logic [31:0]           RAM_OBJ_Do,
    output logic                  RAM_OBJ_EN,
    output logic [3:0]            RAM_OBJ_WE,
    output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
    output logic [31:0]           RAM_OBJ_Di,
    input  logic [31:0]           RAM_NBR_Do,
    output logic                  RAM_NBR_EN,
    output logic [3:0]            RAM_NBR_WE,
    output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
    output logic [31:0]           RAM_NBR_Di,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  bad_index
);

    localparam int unsigned CW = $clog2(MAX_NEIGHBOR_COUNT + 1);
    localparam logic [CW-1:0] FULL = CW'(MAX_NEIGHBOR_COUNT - 1);

    typedef enum logic [3:0] {
        StIdle, StClear, StFaceRd, StInsRd, StInsCnt, StScan, StCmp, StWrV, StWrN, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     vcnt_q, vcnt_d, fcnt_q, fcnt_d;
    logic [31:0]     idx_q, idx_d;
    logic [1:0]      phase_q, phase_d;
    logic [31:0]     a_q, a_d, b_q, b_d, c_q, c_d;
    logic [2:0]      pair_q, pair_d;
    logic [CW-1:0]   n_q, n_d, scan_q, scan_d;
    logic            ovf_q, ovf_d, bad_q, bad_d;

    logic [31:0]           u, v;
    logic [ADDR_WIDTH-1:0] slot_base, face_addr, clear_addr;
    logic                  last_face, adv_pair, adv_face;

    function automatic logic idx_ok(input logic [31:0] x, input logic [31:0] lim);
        return (x != 32'd0) && (x <= lim);
    endfunction

    // Insertion order: a<-b, b<-a, b<-c, c<-b, c<-a, a<-c
    always_comb begin
        u = a_q;
        v = c_q;
        case (pair_q)
            3'd0: begin u = a_q; v = b_q; end
            3'd1: begin u = b_q; v = a_q; end
            3'd2: begin u = b_q; v = c_q; end
            3'd3: begin u = c_q; v = b_q; end
            3'd4: begin u = c_q; v = a_q; end
            default: begin u = a_q; v = c_q; end
        endcase
    end

    assign slot_base  = ADDR_WIDTH'((u - 32'd1) * MAX_NEIGHBOR_COUNT);
    assign clear_addr = ADDR_WIDTH'(idx_q * MAX_NEIGHBOR_COUNT);
    assign face_addr  = ADDR_WIDTH'(32'd3 * vcnt_q + 32'd3 * idx_q + 32'(phase_q));
    assign last_face  = (idx_q + 32'd1 == fcnt_q);

    assign busy       = (state_q != StIdle) && (state_q != StDone);
    assign done       = (state_q == StDone);
    assign overflow   = ovf_q;
    assign bad_index  = bad_q;
    assign RAM_OBJ_WE = 4'h0;
    assign RAM_OBJ_Di = 32'h0;

    always_comb begin
        state_d    = state_q;
        vcnt_d     = vcnt_q;
        fcnt_d     = fcnt_q;
        idx_d      = idx_q;
        phase_d    = phase_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        pair_d     = pair_q;
        n_d        = n_q;
        scan_d     = scan_q;
        ovf_d      = ovf_q;
        bad_d      = bad_q;
        adv_pair   = 1'b0;
        adv_face   = 1'b0;
        RAM_OBJ_EN = 1'b0;
        RAM_OBJ_A  = '0;
        RAM_NBR_EN = 1'b0;
        RAM_NBR_WE = 4'h0;
        RAM_NBR_A  = '0;
        RAM_NBR_Di = 32'h0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    vcnt_d  = vertex_count;
                    fcnt_d  = face_count;
                    idx_d   = 32'd0;
                    phase_d = 2'd0;
                    ovf_d   = 1'b0;
                    bad_d   = 1'b0;
                    if (vertex_count != 32'd0) state_d = StClear;
                    else if (face_count == 32'd0) state_d = StDone;
                    else state_d = StFaceRd;
                end
            end
            StClear: begin
                RAM_NBR_EN = 1'b1;
                RAM_NBR_WE = 4'hF;
                RAM_NBR_A  = clear_addr;
                if (idx_q == vcnt_q - 32'd1) begin
                    idx_d   = 32'd0;
                    phase_d = 2'd0;
                    state_d = (fcnt_q == 32'd0) ? StDone : StFaceRd;
                end else begin
                    idx_d = idx_q + 32'd1;
                end
            end
            StFaceRd: begin
                // Addresses issued in phases 0..2; data lands one phase later.
                RAM_OBJ_EN = (phase_q != 2'd3);
                RAM_OBJ_A  = face_addr;
                phase_d    = phase_q + 2'd1;
                case (phase_q)
                    2'd1: a_d = RAM_OBJ_Do;
                    2'd2: b_d = RAM_OBJ_Do;
                    2'd3: begin
                        c_d = RAM_OBJ_Do;
                        if (!idx_ok(a_q, vcnt_q) || !idx_ok(b_q, vcnt_q) ||
                            !idx_ok(RAM_OBJ_Do, vcnt_q)) begin
                            bad_d    = 1'b1;
                            adv_face = 1'b1;
                        end else begin
                            pair_d  = 3'd0;
                            state_d = StInsRd;
                        end
                    end
                    default: ;
                endcase
            end
            StInsRd: begin
                if (u == v) begin
                    adv_pair = 1'b1;
                end else begin
                    RAM_NBR_EN = 1'b1;
                    RAM_NBR_A  = slot_base;
                    state_d    = StInsCnt;
                end
            end
            StInsCnt: begin
                n_d     = RAM_NBR_Do[CW-1:0];
                scan_d  = CW'(1);
                state_d = StScan;
            end
            StScan: begin
                if (scan_q > n_q) begin
                    if (n_q < FULL) begin
                        state_d = StWrV;
                    end else begin
                        ovf_d    = 1'b1;
                        adv_pair = 1'b1;
                    end
                end else begin
                    RAM_NBR_EN = 1'b1;
                    RAM_NBR_A  = slot_base + ADDR_WIDTH'(scan_q);
                    state_d    = StCmp;
                end
            end
            StCmp: begin
                if (RAM_NBR_Do == v) begin
                    adv_pair = 1'b1;
                end else begin
                    scan_d  = scan_q + CW'(1);
                    state_d = StScan;
                end
            end
            StWrV: begin
                RAM_NBR_EN = 1'b1;
                RAM_NBR_WE = 4'hF;
                RAM_NBR_A  = slot_base + ADDR_WIDTH'(n_q) + ADDR_WIDTH'(1);
                RAM_NBR_Di = v;
                state_d    = StWrN;
            end
            StWrN: begin
                RAM_NBR_EN = 1'b1;
                RAM_NBR_WE = 4'hF;
                RAM_NBR_A  = slot_base;
                RAM_NBR_Di = 32'(n_q) + 32'd1;
                adv_pair   = 1'b1;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (adv_pair) begin
            if (pair_q == 3'd5) begin
                adv_face = 1'b1;
            end else begin
                pair_d  = pair_q + 3'd1;
                state_d = StInsRd;
            end
        end
        if (adv_face) begin
            idx_d   = idx_q + 32'd1;
            phase_d = 2'd0;
            state_d = last_face ? StDone : StFaceRd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            vcnt_q  <= 32'd0;
            fcnt_q  <= 32'd0;
            idx_q   <= 32'd0;
            phase_q <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            c_q     <= 32'd0;
            pair_q  <= 3'd0;
            n_q     <= '0;
            scan_q  <= '0;
            ovf_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vcnt_q  <= vcnt_d;
            fcnt_q  <= fcnt_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            pair_q  <= pair_d;
            n_q     <= n_d;
            scan_q  <= scan_d;
            ovf_q   <= ovf_d;
            bad_q   <= bad_d;
        end
    end

endmodule
